mem_port_arbiter: RTL and testbench

- Shares one single-ported 16-bit word memory between two requesters: the instruction-fetch front end and the data (load/store) stage.
- Decides each cycle which requester owns the port and drives the memory command.
- Tracks in-flight reads through the fixed memory read latency and routes the returned data to its owner.
- Supports pipeline flush of speculative fetches and prevents fetch starvation behind continuous data traffic.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 80 ++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request, grant, return and memory-command signals shared by the fetch port,
// the data port and the single-ported memory.
interface mem_port_arbiter_if;
    logic        f_req;
    logic [14:0] f_addr;
    logic        f_flush;
    logic        f_gnt;
    logic        f_rvalid;
    logic [15:0] f_rdata;

    logic        d_req;
    logic        d_we;
    logic [14:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;

    logic        mem_ren;
    logic        mem_wen;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    // Handshake: a request is taken in the same cycle its gnt is high.
    // Requesters hold req/addr/wdata until that cycle. Read data arrives as a
    // one-cycle rvalid pulse with no backpressure.
    modport slave (
        input  f_req, f_addr, f_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_ren, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, f_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_ren, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the data
// stage, and routes returning read data to whoever issued the read.
module mem_port_arbiter #(
    parameter int RD_LATENCY = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]            starve_cnt;
    logic [RD_LATENCY-1:0] pipe_v;
    logic [RD_LATENCY-1:0] pipe_f;
    logic                  f_gnt_c;
    logic                  d_gnt_c;
    logic                  rd_issue;
    logic                  out_fetch;
    logic                  out_data;

    // Data normally wins; fetch is forced through once it has waited out its quota.
    always_comb begin
        f_gnt_c = rst_n && bus.f_req && (!bus.d_req || (starve_cnt == STARVE_LIM));
        d_gnt_c = rst_n && bus.d_req && !f_gnt_c;
        rd_issue = f_gnt_c || (d_gnt_c && !bus.d_we);
    end

    always_comb begin
        bus.f_gnt     = f_gnt_c;
        bus.d_gnt     = d_gnt_c;
        bus.mem_ren   = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = 15'd0;
        bus.mem_wdata = 16'd0;
        if (d_gnt_c) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            bus.mem_wen   = bus.d_we;
            bus.mem_ren   = !bus.d_we;
        end else if (f_gnt_c) begin
            bus.mem_addr = bus.f_addr;
            bus.mem_ren  = 1'b1;
        end
    end

    // A flush also kills a fetch return sitting at the output stage this cycle.
    always_comb begin
        out_fetch    = pipe_v[RD_LATENCY-1] && pipe_f[RD_LATENCY-1] && !bus.f_flush;
        out_data     = pipe_v[RD_LATENCY-1] && !pipe_f[RD_LATENCY-1];
        bus.f_rvalid = out_fetch;
        bus.d_rvalid = out_data;
        bus.f_rdata  = out_fetch ? bus.mem_rdata : 16'd0;
        bus.d_rdata  = out_data  ? bus.mem_rdata : 16'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v     <= '0;
            pipe_f     <= '0;
            starve_cnt <= 4'd0;
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                pipe_v[i] <= pipe_v[i-1] && !(bus.f_flush && pipe_f[i-1]);
                pipe_f[i] <= pipe_f[i-1];
            end
            // The fetch granted alongside a flush is the redirect target and survives.
            pipe_v[0] <= rd_issue;
            pipe_f[0] <= f_gnt_c;

            if (f_gnt_c || !bus.f_req) begin
                starve_cnt <= 4'd0;
            end else if (d_gnt_c && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a queue-based model of grants and read returns.
module tb_mem_port_arbiter;

    localparam int L    = 2;
    localparam int SMAX = 4;
    localparam int W    = 69;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.RD_LATENCY(L), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory: writes land at the grant edge, reads return L cycles after the strobe.
    logic [15:0] mem [0:32767];
    logic        hist_v [L];
    logic [15:0] hist_d [L];
    logic [15:0] junk;

    always @(posedge clk) begin
        if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
        hist_v[0] <= bus.mem_ren;
        hist_d[0] <= mem[bus.mem_addr];
        for (int i = 1; i < L; i++) begin
            hist_v[i] <= hist_v[i-1];
            hist_d[i] <= hist_d[i-1];
        end
        junk <= 16'($urandom);
    end
    assign bus.mem_rdata = hist_v[L-1] ? hist_d[L-1] : junk;

    // Reference model: pending returns as {owner_is_fetch, data} with due cycle.
    int          cyc    = 0;
    int          waited = 0;
    logic [16:0] exp_q[$];
    int          due_q[$];

    task automatic step(input logic rst, input logic fr, input logic [14:0] fa,
                        input logic ff, input logic dr, input logic dw,
                        input logic [14:0] da, input logic [15:0] dwd,
                        output logic [W-1:0] obs, output logic [W-1:0] exp);
        logic        fg = 0, dg = 0, ren = 0, wen = 0, fv = 0, dv = 0, due = 0;
        logic [14:0] ma = 0;
        logic [15:0] mw = 0, fd = 0, dd = 0;
        @(negedge clk);
        rst_n = rst;
        bus.f_req = fr; bus.f_addr = fa; bus.f_flush = ff;
        bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dwd;
        #1;
        if (rst) begin
            if (ff) begin
                for (int i = exp_q.size() - 1; i >= 0; i--) begin
                    if (exp_q[i][16]) begin
                        exp_q.delete(i);
                        due_q.delete(i);
                    end
                end
            end
            due = (due_q.size() > 0) && (due_q[0] == cyc);
            if (due) begin
                if (exp_q[0][16]) begin fv = 1; fd = exp_q[0][15:0]; end
                else begin dv = 1; dd = exp_q[0][15:0]; end
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
            fg = fr && (!dr || waited == SMAX);
            dg = dr && !fg;
            if (dg) begin ma = da; mw = dwd; wen = dw; ren = !dw; end
            else if (fg) begin ma = fa; ren = 1; end
            if (ren) begin
                exp_q.push_back({fg, mem[ma]});
                due_q.push_back(cyc + L);
            end
            if (fg || !fr) waited = 0;
            else if (dg && waited < SMAX) waited++;
        end else begin
            exp_q.delete();
            due_q.delete();
            waited = 0;
        end
        cyc++;
        exp = {fg, dg, ren, wen, ma, mw, fv, fd, dv, dd};
        obs = {bus.f_gnt, bus.d_gnt, bus.mem_ren, bus.mem_wen, bus.mem_addr, bus.mem_wdata,
               bus.f_rvalid, bus.f_rdata, bus.d_rvalid, bus.d_rdata};
    endtask

    task automatic test_reset();
        logic [W-1:0] obs, exp;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 15'h5, 0, 1, 0, 15'h6, 16'h77, obs, exp);
            checks++;
            if (obs !== '0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%h want=0", cyc, obs);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 15'h5, 0, 1, 0, 15'h6, 16'h77, obs, exp);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_release_model cyc=%0d got=%h want=%h", cyc, obs, exp);
            end
            checks++;
            if ({bus.f_gnt, bus.d_gnt} !== ((i == 4) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL reset_release_grant i=%0d got=%b want=%b", i,
                         {bus.f_gnt, bus.d_gnt}, (i == 4) ? 2'b10 : 2'b01);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, obs, exp);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_drain cyc=%0d got=%h want=%h", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_fetch_single();
        logic [W-1:0] obs, exp;
        step(1, 0, 0, 0, 1, 1, 15'h0010, 16'hA5A5, obs, exp);
        step(1, 1, 15'h0010, 0, 0, 0, 0, 0, obs, exp);
        checks++;
        if ({bus.f_gnt, bus.d_gnt, bus.mem_ren, bus.mem_addr} !== {3'b101, 15'h0010}) begin
            failures++;
            $display("FAIL fetch_grant got=%b/%b/%b/%h want=1/0/1/0010",
                     bus.f_gnt, bus.d_gnt, bus.mem_ren, bus.mem_addr);
        end
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, obs, exp);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL fetch_model cyc=%0d got=%h want=%h", cyc, obs, exp);
            end
            checks++;
            if ({bus.f_rvalid, bus.f_rdata, bus.d_rvalid} !==
                ((i == 2) ? {1'b1, 16'hA5A5, 1'b0} : 18'd0)) begin
                failures++;
                $display("FAIL fetch_return i=%0d got=%b/%h/%b", i, bus.f_rvalid,
                         bus.f_rdata, bus.d_rvalid);
            end
        end
    endtask

    task automatic test_starvation();
        logic [W-1:0] obs, exp;
        for (int i = 0; i < 14; i++) begin
            if (i < 12) step(1, 1, 15'(i), 0, 1, 0, 15'($urandom_range(0, 31)), 0, obs, exp);
            else step(1, 0, 0, 0, 0, 0, 0, 0, obs, exp);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL starve_model cyc=%0d got=%h want=%h", cyc, obs, exp);
            end
            if (i < 12) begin
                checks++;
                if ({bus.f_gnt, bus.d_gnt} !== ((i % 5 == 4) ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL starve_pattern i=%0d got=%b", i, {bus.f_gnt, bus.d_gnt});
                end
            end
        end
    endtask

    task automatic test_store_load();
        logic [W-1:0] obs, exp;
        step(1, 0, 0, 0, 1, 1, 15'h0020, 16'h1234, obs, exp);
        checks++;
        if ({bus.d_gnt, bus.mem_wen, bus.mem_ren, bus.mem_addr, bus.mem_wdata} !==
            {3'b110, 15'h0020, 16'h1234}) begin
            failures++;
            $display("FAIL store_cmd got=%b%b%b/%h/%h", bus.d_gnt, bus.mem_wen,
                     bus.mem_ren, bus.mem_addr, bus.mem_wdata);
        end
        step(1, 0, 0, 0, 1, 0, 15'h0020, 0, obs, exp);
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, obs, exp);
            checks++;
            if ({bus.d_rvalid, bus.d_rdata} !== ((i == 2) ? {1'b1, 16'h1234} : 17'd0)) begin
                failures++;
                $display("FAIL store_load_return i=%0d got=%b/%h", i, bus.d_rvalid, bus.d_rdata);
            end
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] obs, exp;
        step(1, 0, 0, 0, 1, 1, 15'h0030, 16'h1111, obs, exp);
        step(1, 0, 0, 0, 1, 1, 15'h0031, 16'hBEEF, obs, exp);
        step(1, 1, 15'h0030, 0, 0, 0, 0, 0, obs, exp);
        step(1, 1, 15'h0031, 1, 0, 0, 0, 0, obs, exp);
        for (int i = 2; i <= 4; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, obs, exp);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL flush_model cyc=%0d got=%h want=%h", cyc, obs, exp);
            end
            checks++;
            if ({bus.f_rvalid, bus.f_rdata} !== ((i == 3) ? {1'b1, 16'hBEEF} : 17'd0)) begin
                failures++;
                $display("FAIL flush_return i=%0d got=%b/%h", i, bus.f_rvalid, bus.f_rdata);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] obs, exp;
        step(1, 0, 0, 0, 1, 0, 15'h0031, 0, obs, exp);
        step(0, 1, 15'h3, 0, 1, 0, 15'h4, 0, obs, exp);
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h want=0", obs);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, obs, exp);
            checks++;
            if (bus.d_rvalid !== 1'b0 || obs !== exp) begin
                failures++;
                $display("FAIL midreset_drop i=%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] obs, exp;
        for (int i = 0; i < 400; i++) begin
            step(1, 1'($urandom_range(0, 1)), 15'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 15'($urandom_range(0, 15)),
                 16'($urandom), obs, exp);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        bus.f_req = 0; bus.f_addr = 0; bus.f_flush = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        #2 rst_n = 1'b0;
        test_reset();
        test_fetch_single();
        test_starvation();
        test_store_load();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
